// File: rtl/chunk_adder.sv
// Multi-cycle adder/subtractor that adds SLICE bits per clock, LSB slice first,
// with a valid/ready handshake on both the operand and the result side.
module chunk_adder #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] full;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_sl;
  logic             c_sl;
  logic             last;
  logic             ovf_next;

  assign in_ready  = (state == IDLE) && !reset;
  assign out_valid = (state == DONE);
  assign last      = (cnt == CW'(NSLICE - 1));

  // One slice of the ripple: b_q already holds ~b when subtracting.
  always_comb begin
    a_sl = a_q[int'(cnt) * SLICE +: SLICE];
    b_sl = b_q[int'(cnt) * SLICE +: SLICE];
    {c_sl, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE + 1)'(carry);
    full = acc;
    full[int'(cnt) * SLICE +: SLICE] = s_sl;
    // Same-sign operands giving a different-sign result is equivalent to
    // carry-in XOR carry-out at the MSB.
    ovf_next = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (full[WIDTH-1] != a_q[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // Result registers only load on the final slice so partial sums never leak.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      carryout <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= subtract ? ~b : b;
            carry <= subtract;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= full;
          carry <= c_sl;
          if (last) begin
            cnt      <= '0;
            sum      <= full;
            carryout <= c_sl;
            overflow <= ovf_next;
            zero     <= (full == '0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_adder.sv
// Directed self-checking bench for chunk_adder with WIDTH=8, SLICE=2.
module tb_chunk_adder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       subtract;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carryout;
  logic       overflow;
  logic       zero;

  int nchecks = 0;
  int nerrors = 0;

  chunk_adder #(.WIDTH(8), .SLICE(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .subtract(subtract), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .carryout(carryout),
    .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set for a single edge (block must be idle).
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic sub);
    a = av; b = bv; subtract = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cycles++;
      if (out_valid) return;
    end
    cycles = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; a = 8'h11; b = 8'h22; subtract = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    nchecks++;
    if (in_ready !== 1'b0) begin nerrors++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
    nchecks++;
    if ({out_valid, sum, carryout, overflow, zero} !== 12'h000) begin
      nerrors++;
      $display("[TB] FAIL reset_outputs got v=%b s=%h c=%b o=%b z=%b want all 0", out_valid, sum, carryout, overflow, zero);
    end
    reset = 1'b0; in_valid = 1'b0;
    #1;
    nchecks++;
    if (in_ready !== 1'b1) begin nerrors++; $display("[TB] FAIL post_reset_in_ready got %b want 1", in_ready); end
    tick();
    nchecks++;
    if (out_valid !== 1'b0) begin nerrors++; $display("[TB] FAIL reset_no_accept got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_add();
    int cyc;
    start_op(8'h7F, 8'h01, 1'b0);
    wait_done(cyc);
    nchecks++;
    if (cyc !== 4) begin nerrors++; $display("[TB] FAIL add_latency got %0d want 4", cyc); end
    nchecks++;
    if ({sum, carryout, overflow, zero} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
      nerrors++;
      $display("[TB] FAIL add_7f_01 got s=%h c=%b o=%b z=%b want s=80 c=0 o=1 z=0", sum, carryout, overflow, zero);
    end
    release_result();
    nchecks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h80) begin
      nerrors++;
      $display("[TB] FAIL add_release got rdy=%b v=%b s=%h want rdy=1 v=0 s=80", in_ready, out_valid, sum);
    end
    start_op(8'hFF, 8'hFF, 1'b0);
    wait_done(cyc);
    nchecks++;
    if (cyc !== 4 || {sum, carryout, overflow, zero} !== {8'hFE, 1'b1, 1'b0, 1'b0}) begin
      nerrors++;
      $display("[TB] FAIL add_ff_ff got cyc=%0d s=%h c=%b o=%b z=%b want cyc=4 s=fe c=1 o=0 z=0", cyc, sum, carryout, overflow, zero);
    end
    release_result();
  endtask

  task automatic test_subtract();
    int cyc;
    start_op(8'h05, 8'h05, 1'b1);
    wait_done(cyc);
    nchecks++;
    if (cyc !== 4 || {sum, carryout, overflow, zero} !== {8'h00, 1'b1, 1'b0, 1'b1}) begin
      nerrors++;
      $display("[TB] FAIL sub_05_05 got cyc=%0d s=%h c=%b o=%b z=%b want cyc=4 s=00 c=1 o=0 z=1", cyc, sum, carryout, overflow, zero);
    end
    release_result();
    start_op(8'h01, 8'h02, 1'b1);
    wait_done(cyc);
    nchecks++;
    if (cyc !== 4 || {sum, carryout, overflow, zero} !== {8'hFF, 1'b0, 1'b0, 1'b0}) begin
      nerrors++;
      $display("[TB] FAIL sub_01_02 got cyc=%0d s=%h c=%b o=%b z=%b want cyc=4 s=ff c=0 o=0 z=0", cyc, sum, carryout, overflow, zero);
    end
    release_result();
    start_op(8'h80, 8'h01, 1'b1);
    wait_done(cyc);
    nchecks++;
    if (cyc !== 4 || {sum, carryout, overflow, zero} !== {8'h7F, 1'b1, 1'b1, 1'b0}) begin
      nerrors++;
      $display("[TB] FAIL sub_80_01 got cyc=%0d s=%h c=%b o=%b z=%b want cyc=4 s=7f c=1 o=1 z=0", cyc, sum, carryout, overflow, zero);
    end
    release_result();
  endtask

  task automatic test_hold();
    int cyc;
    start_op(8'h10, 8'h20, 1'b0);
    wait_done(cyc);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 8'hA0 + 8'(i); b = 8'h5A ^ 8'(i); subtract = i[0];
      nchecks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {sum, carryout, overflow, zero} !== {8'h30, 3'b000}) begin
        nerrors++;
        $display("[TB] FAIL hold_%0d got v=%b rdy=%b s=%h c=%b o=%b z=%b want v=1 rdy=0 s=30 flags 000",
                 i, out_valid, in_ready, sum, carryout, overflow, zero);
      end
      tick();
    end
    in_valid = 1'b0;
    release_result();
    nchecks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h30) begin
      nerrors++;
      $display("[TB] FAIL hold_release got rdy=%b v=%b s=%h want rdy=1 v=0 s=30", in_ready, out_valid, sum);
    end
  endtask

  task automatic test_change_during_run();
    int cyc;
    a = 8'h3C; b = 8'h0A; subtract = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      a = 8'($urandom); b = 8'($urandom); subtract = 1'($urandom);
      tick();
      cyc++;
      if (out_valid) break;
    end
    nchecks++;
    if (cyc !== 4 || {sum, carryout, overflow, zero} !== {8'h46, 3'b000}) begin
      nerrors++;
      $display("[TB] FAIL run_latch got cyc=%0d s=%h c=%b o=%b z=%b want cyc=4 s=46 c=0 o=0 z=0", cyc, sum, carryout, overflow, zero);
    end
    release_result();
  endtask

  task automatic test_reset_abort();
    int seen;
    // Leave a nonzero result with flags set so the clear is observable.
    start_op(8'h80, 8'h01, 1'b1);
    wait_done(seen);
    release_result();
    start_op(8'h7F, 8'h01, 1'b0);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    nchecks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || {sum, carryout, overflow, zero} !== 11'h000) begin
      nerrors++;
      $display("[TB] FAIL abort_clear got v=%b rdy=%b s=%h c=%b o=%b z=%b want v=0 rdy=1 all 0",
               out_valid, in_ready, sum, carryout, overflow, zero);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid || sum !== 8'h00) seen++;
    end
    nchecks++;
    if (seen !== 0) begin nerrors++; $display("[TB] FAIL abort_no_result got %0d bad cycles want 0", seen); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; subtract = 1'b0; out_ready = 1'b0;
    test_reset();
    test_add();
    test_subtract();
    test_hold();
    test_change_during_run();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
